// File: rtl/chan_pkg.sv
// Shared constants and types for the channel router: bus widths, the default status
// channel address and the byte order of the status readout.
package chan_pkg;

    localparam int CHAN_ADDR_W = 7;
    localparam int CHAN_DATA_W = 8;
    localparam int CHAN_TAG_W  = 4;   // wide enough for up to 16 endpoints
    localparam int COUNT_W     = 16;

    localparam int DEFAULT_STATUS_ADDR = 127;

    // Byte order of the 4-byte status readout.
    typedef enum logic [1:0] {
        STAT_BYTE_LO = 2'd0,
        STAT_BYTE_HI = 2'd1,
        STAT_DROP_LO = 2'd2,
        STAT_DROP_HI = 2'd3
    } stat_idx_e;

    // Byte 0 is read live; the other three come from the snapshot taken when byte 0 is consumed.
    function automatic logic [CHAN_DATA_W-1:0] stat_byte(
        input stat_idx_e            idx,
        input logic [COUNT_W-1:0]   live_bytes,
        input logic [2*COUNT_W-1:0] shadow
    );
        logic [CHAN_DATA_W-1:0] b;
        b = '0;
        unique case (idx)
            STAT_BYTE_LO: b = live_bytes[7:0];
            STAT_BYTE_HI: b = shadow[15:8];
            STAT_DROP_LO: b = shadow[23:16];
            STAT_DROP_HI: b = shadow[31:24];
            default:      b = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/chan_skid_reg.sv
// One-entry host-to-endpoint stage: holds a data byte, the endpoint tag it is bound to,
// and a full flag. A load on the same edge as a drain reloads the stage.
module chan_skid_reg
    import chan_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [CHAN_DATA_W-1:0] load_data,
    input  logic [CHAN_TAG_W-1:0]  load_tag,
    input  logic                   drain,
    output logic                   full,
    output logic [CHAN_DATA_W-1:0] data,
    output logic [CHAN_TAG_W-1:0]  tag
);

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of its inputs, independent of the order the blocks are evaluated.
    // NOTE: the data/tag holding register is reset too; it is a single byte, not a
    // memory array, and a known value keeps the shared endpoint data bus clean after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
            data <= '0;
            tag  <= '0;
        end else if (load) begin
            full <= 1'b1;
            data <= load_data;
            tag  <= load_tag;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/chan_router.sv
// Routes comm_fpga_fx2 channel traffic to NUM_CHAN endpoints and keeps byte/drop counters.
// Define CHAN_ROUTER_STATUS_EN to build the read-only status channel at STATUS_ADDR.
module chan_router
    import chan_pkg::*;
#(
    parameter int NUM_CHAN    = 4,
    parameter int BASE_ADDR   = 0,
    parameter int STATUS_ADDR = DEFAULT_STATUS_ADDR
) (
    input  logic                            clk_in,
    input  logic                            reset_in,
    input  logic [CHAN_ADDR_W-1:0]          chanAddr_in,
    input  logic [CHAN_DATA_W-1:0]          h2fData_in,
    input  logic                            h2fValid_in,
    output logic                            h2fReady_out,
    output logic [CHAN_DATA_W-1:0]          f2hData_out,
    output logic                            f2hValid_out,
    input  logic                            f2hReady_in,
    output logic [CHAN_DATA_W-1:0]          epH2fData_out,
    output logic [NUM_CHAN-1:0]             epH2fValid_out,
    input  logic [NUM_CHAN-1:0]             epH2fReady_in,
    input  logic [CHAN_DATA_W*NUM_CHAN-1:0] epF2hData_in,
    input  logic [NUM_CHAN-1:0]             epF2hValid_in,
    output logic [NUM_CHAN-1:0]             epF2hReady_out,
    output logic [COUNT_W-1:0]              byteCount_out,
    output logic [COUNT_W-1:0]              dropCount_out
);

    if (NUM_CHAN < 1 || NUM_CHAN > 16) begin : g_bad_num_chan
        $error("chan_router: NUM_CHAN must be 1..16");
    end
    if (STATUS_ADDR >= BASE_ADDR && STATUS_ADDR < BASE_ADDR + NUM_CHAN) begin : g_bad_status
        $error("chan_router: STATUS_ADDR overlaps the endpoint range");
    end

    logic                   h_full;
    logic [CHAN_DATA_W-1:0] h_buf;
    logic [CHAN_TAG_W-1:0]  h_tag;

    logic [7:0]             addr_off;
    logic                   addr_mapped;
    logic                   status_hit;
    logic                   ep_ready_sel;
    logic                   accept;
    logic                   load;
    logic                   drain;
    logic                   drop;
    logic                   stat_clear;
    logic [CHAN_DATA_W-1:0] stat_data;

    logic [COUNT_W-1:0]     byte_count;
    logic [COUNT_W-1:0]     drop_count;

    // Addresses below BASE_ADDR wrap to a large offset, so one compare covers both bounds.
    assign addr_off    = {1'b0, chanAddr_in} - 8'(BASE_ADDR);
    assign addr_mapped = (addr_off < 8'(NUM_CHAN));

    // NOTE: every signal assigned in an always_comb gets a default before any branch,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        ep_ready_sel = 1'b0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            if (h_tag == CHAN_TAG_W'(i)) ep_ready_sel = epH2fReady_in[i];
        end
    end

    assign h2fReady_out = !h_full || ep_ready_sel;
    assign accept       = h2fValid_in && h2fReady_out;
    assign load         = accept && addr_mapped;
    assign drain        = h_full && ep_ready_sel;
    assign drop         = accept && !addr_mapped && !status_hit;
    assign stat_clear   = accept && status_hit;

    // The pending byte keeps its captured tag, so an address change cannot misroute it.
    chan_skid_reg u_stage (
        .clk       (clk_in),
        .rst       (reset_in),
        .load      (load),
        .load_data (h2fData_in),
        .load_tag  (addr_off[CHAN_TAG_W-1:0]),
        .drain     (drain),
        .full      (h_full),
        .data      (h_buf),
        .tag       (h_tag)
    );

    assign epH2fData_out = h_buf;

    always_comb begin
        epH2fValid_out = '0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            epH2fValid_out[i] = h_full && (h_tag == CHAN_TAG_W'(i));
        end
    end

    // Read path is purely combinational; unmapped reads return an always-valid zero byte.
    always_comb begin
        f2hData_out    = '0;
        f2hValid_out   = 1'b1;
        epF2hReady_out = '0;
        if (status_hit) begin
            f2hData_out = stat_data;
        end else begin
            for (int i = 0; i < NUM_CHAN; i++) begin
                if (addr_off == 8'(i)) begin
                    f2hData_out       = epF2hData_in[i*CHAN_DATA_W +: CHAN_DATA_W];
                    f2hValid_out      = epF2hValid_in[i];
                    epF2hReady_out[i] = f2hReady_in;
                end
            end
        end
    end

    // A status write clears both counters and wins over a same-edge increment.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            byte_count <= '0;
            drop_count <= '0;
        end else if (stat_clear) begin
            byte_count <= '0;
            drop_count <= '0;
        end else begin
            if (drain) byte_count <= byte_count + 16'd1;
            if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
        end
    end

    assign byteCount_out = byte_count;
    assign dropCount_out = drop_count;

`ifdef CHAN_ROUTER_STATUS_EN
    localparam logic [CHAN_ADDR_W-1:0] STATUS_CODE = CHAN_ADDR_W'(STATUS_ADDR);

    stat_idx_e              stat_idx;
    logic [2*COUNT_W-1:0]   stat_shadow;

    assign status_hit = (chanAddr_in == STATUS_CODE);
    assign stat_data  = stat_byte(stat_idx, byte_count, stat_shadow);

    // Consuming byte 0 freezes both counters so the remaining three bytes agree with it.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            stat_idx    <= STAT_BYTE_LO;
            stat_shadow <= '0;
        end else begin
            if (!status_hit) begin
                stat_idx <= STAT_BYTE_LO;
            end else if (f2hReady_in) begin
                stat_idx <= stat_idx_e'(stat_idx + 2'd1);
            end
            if (status_hit && f2hReady_in && (stat_idx == STAT_BYTE_LO)) begin
                stat_shadow <= {drop_count, byte_count};
            end
        end
    end
`else
    assign status_hit = 1'b0;
    assign stat_data  = '0;
`endif

endmodule

// File: tb/tb_chan_router.sv
// Self-checking bench for chan_router: a transaction-level model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_chan_router;
    import chan_pkg::*;

    localparam int NUM_CHAN    = 4;
    localparam int BASE_ADDR   = 0;
    localparam int STATUS_ADDR = 127;
`ifdef CHAN_ROUTER_STATUS_EN
    localparam bit STATUS_EN = 1'b1;
`else
    localparam bit STATUS_EN = 1'b0;
`endif

    logic                            clk_in = 1'b0;
    logic                            reset_in = 1'b1;
    logic [CHAN_ADDR_W-1:0]          chanAddr_in = '0;
    logic [CHAN_DATA_W-1:0]          h2fData_in = '0;
    logic                            h2fValid_in = 1'b0;
    logic                            h2fReady_out;
    logic [CHAN_DATA_W-1:0]          f2hData_out;
    logic                            f2hValid_out;
    logic                            f2hReady_in = 1'b0;
    logic [CHAN_DATA_W-1:0]          epH2fData_out;
    logic [NUM_CHAN-1:0]             epH2fValid_out;
    logic [NUM_CHAN-1:0]             epH2fReady_in = '1;
    logic [CHAN_DATA_W*NUM_CHAN-1:0] epF2hData_in = 32'h44332211;
    logic [NUM_CHAN-1:0]             epF2hValid_in = '0;
    logic [NUM_CHAN-1:0]             epF2hReady_out;
    logic [COUNT_W-1:0]              byteCount_out;
    logic [COUNT_W-1:0]              dropCount_out;

    always #5 clk_in = ~clk_in;

    chan_router #(
        .NUM_CHAN    (NUM_CHAN),
        .BASE_ADDR   (BASE_ADDR),
        .STATUS_ADDR (STATUS_ADDR)
    ) dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .chanAddr_in    (chanAddr_in),
        .h2fData_in     (h2fData_in),
        .h2fValid_in    (h2fValid_in),
        .h2fReady_out   (h2fReady_out),
        .f2hData_out    (f2hData_out),
        .f2hValid_out   (f2hValid_out),
        .f2hReady_in    (f2hReady_in),
        .epH2fData_out  (epH2fData_out),
        .epH2fValid_out (epH2fValid_out),
        .epH2fReady_in  (epH2fReady_in),
        .epF2hData_in   (epF2hData_in),
        .epF2hValid_in  (epF2hValid_in),
        .epF2hReady_out (epF2hReady_out),
        .byteCount_out  (byteCount_out),
        .dropCount_out  (dropCount_out)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        int         chan;
        logic [7:0] data;
    } xfer_t;

    xfer_t m_pend[$];      // at most one byte waiting for its endpoint
    xfer_t got[$];         // bytes the DUT actually handed to endpoints
    int    m_bytes = 0;
    int    m_drops = 0;
    int    m_idx   = 0;
    int    s_bytes = 0;
    int    s_drops = 0;

    function automatic int addr_offset(input logic [CHAN_ADDR_W-1:0] a);
        return int'(a) - BASE_ADDR;
    endfunction

    always @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            m_pend.delete();
            m_bytes = 0;
            m_drops = 0;
            m_idx   = 0;
            s_bytes = 0;
            s_drops = 0;
        end else begin
            bit deliver, ready, accept, on_status, mapped;
            int off;
            off       = addr_offset(chanAddr_in);
            mapped    = (off >= 0) && (off < NUM_CHAN);
            on_status = STATUS_EN && (int'(chanAddr_in) == STATUS_ADDR);
            deliver   = (m_pend.size() != 0) && epH2fReady_in[m_pend[0].chan];
            ready     = (m_pend.size() == 0) || deliver;
            accept    = h2fValid_in && ready;

            if (!on_status) m_idx = 0;
            else if (f2hReady_in) begin
                if (m_idx == 0) begin
                    s_bytes = m_bytes;
                    s_drops = m_drops;
                end
                m_idx = (m_idx + 1) % 4;
            end

            if (deliver) begin
                void'(m_pend.pop_front());
                m_bytes = (m_bytes + 1) % 65536;
            end
            if (accept && mapped) m_pend.push_back('{chan: off, data: h2fData_in});
            if (accept && !mapped && !on_status && m_drops < 65535) m_drops++;
            if (accept && on_status) begin
                m_bytes = 0;
                m_drops = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk_in) begin
        logic        exp_ready;
        logic [3:0]  exp_valid;
        logic [7:0]  exp_rd;
        logic        exp_rd_valid;
        logic [3:0]  exp_rd_ack;
        int          off;

        for (int i = 0; i < NUM_CHAN; i++) begin
            if (epH2fValid_out[i] && epH2fReady_in[i]) got.push_back('{chan: i, data: epH2fData_out});
        end

        exp_ready = 1'b1;
        exp_valid = '0;
        if (m_pend.size() != 0) begin
            exp_ready = epH2fReady_in[m_pend[0].chan];
            exp_valid = 4'(1 << m_pend[0].chan);
            check("ep_h2f_data", epH2fData_out, m_pend[0].data);
        end
        check("h2f_ready", h2fReady_out, exp_ready);
        check("ep_h2f_valid", epH2fValid_out, exp_valid);

        off          = addr_offset(chanAddr_in);
        exp_rd       = 8'h00;
        exp_rd_valid = 1'b1;
        exp_rd_ack   = '0;
        if (STATUS_EN && int'(chanAddr_in) == STATUS_ADDR) begin
            case (m_idx)
                0:       exp_rd = 8'(m_bytes & 255);
                1:       exp_rd = 8'((s_bytes >> 8) & 255);
                2:       exp_rd = 8'(s_drops & 255);
                default: exp_rd = 8'((s_drops >> 8) & 255);
            endcase
        end else if (off >= 0 && off < NUM_CHAN) begin
            exp_rd       = 8'((epF2hData_in >> (8 * off)) & 32'hFF);
            exp_rd_valid = epF2hValid_in[off];
            exp_rd_ack   = f2hReady_in ? 4'(1 << off) : 4'b0000;
        end
        check("f2h_data", f2hData_out, exp_rd);
        check("f2h_valid", f2hValid_out, exp_rd_valid);
        check("ep_f2h_ready", epF2hReady_out, exp_rd_ack);
        check("byte_count", byteCount_out, 32'(m_bytes));
        check("drop_count", dropCount_out, 32'(m_drops));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic check_got(input string name, input int idx, input int chan, input logic [7:0] data);
        check({name, "_chan"}, 32'(got[idx].chan), 32'(chan));
        check({name, "_data"}, got[idx].data, data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [7:0] stat_exp [5];

        tick(2);
        reset_in = 1'b0;
        #1;
        check("rst_h2f_ready", h2fReady_out, 1'b1);
        check("rst_ep_valid", epH2fValid_out, 4'b0000);
        check("rst_bytes", byteCount_out, 16'd0);
        check("rst_drops", dropCount_out, 16'd0);
        tick();

        // Back-to-back burst to endpoint 1.
        chanAddr_in = 7'd1; h2fData_in = 8'h11; h2fValid_in = 1'b1;
        #1 check("b2b_pre_valid", epH2fValid_out, 4'b0000);
        tick();
        h2fData_in = 8'h22;
        #1 check("b2b_v0", epH2fValid_out, 4'b0010); check("b2b_d0", epH2fData_out, 8'h11);
        tick();
        h2fData_in = 8'h33;
        #1 check("b2b_v1", epH2fValid_out, 4'b0010); check("b2b_d1", epH2fData_out, 8'h22);
        tick();
        h2fValid_in = 1'b0;
        #1 check("b2b_v2", epH2fValid_out, 4'b0010); check("b2b_d2", epH2fData_out, 8'h33);
        tick();
        #1 check("b2b_idle", epH2fValid_out, 4'b0000); check("b2b_bytes", byteCount_out, 16'd3);

        // Backpressure from endpoint 2.
        epH2fReady_in = 4'b1011; chanAddr_in = 7'd2; h2fData_in = 8'hA5; h2fValid_in = 1'b1;
        #1 check("bp_ready_first", h2fReady_out, 1'b1);
        tick();
        h2fData_in = 8'h5A;
        repeat (5) begin
            #1 check("bp_ready_low", h2fReady_out, 1'b0);
            check("bp_hold_data", epH2fData_out, 8'hA5);
            check("bp_hold_valid", epH2fValid_out, 4'b0100);
            tick();
        end
        epH2fReady_in = 4'b1111;
        #1 check("bp_ready_back", h2fReady_out, 1'b1);
        tick();
        h2fValid_in = 1'b0;
        #1 check("bp_second", epH2fData_out, 8'h5A);
        tick();
        #1 check("bp_bytes", byteCount_out, 16'd5);

        // Address change while a byte is pending.
        epH2fReady_in = 4'b1110; chanAddr_in = 7'd0; h2fData_in = 8'hC3; h2fValid_in = 1'b1;
        tick();
        chanAddr_in = 7'd3; h2fData_in = 8'h77;
        repeat (2) begin
            #1 check("sw_stuck_valid", epH2fValid_out, 4'b0001);
            check("sw_stuck_ready", h2fReady_out, 1'b0);
            tick();
        end
        epH2fReady_in = 4'b1111;
        tick();
        h2fValid_in = 1'b0;
        #1 check("sw_new_valid", epH2fValid_out, 4'b1000); check("sw_new_data", epH2fData_out, 8'h77);
        tick();
        #1 check("sw_bytes", byteCount_out, 16'd7);
        check("got_size", 32'(got.size()), 32'd7);
        check_got("got0", 0, 1, 8'h11);
        check_got("got2", 2, 1, 8'h33);
        check_got("got3", 3, 2, 8'hA5);
        check_got("got4", 4, 2, 8'h5A);
        check_got("got5", 5, 0, 8'hC3);
        check_got("got6", 6, 3, 8'h77);

        // Unmapped writes and reads.
        chanAddr_in = 7'd40; h2fData_in = 8'hFF; h2fValid_in = 1'b1;
        #1 check("drop_ready", h2fReady_out, 1'b1);
        tick(2);
        h2fValid_in = 1'b0;
        #1 check("drop_count2", dropCount_out, 16'd2);
        check("drop_no_valid", epH2fValid_out, 4'b0000);
        f2hReady_in = 1'b1;
        #1 check("unm_rd_data", f2hData_out, 8'h00);
        check("unm_rd_valid", f2hValid_out, 1'b1);
        check("unm_rd_ack", epF2hReady_out, 4'b0000);
        chanAddr_in = 7'd2; epF2hValid_in = 4'b0100;
        #1 check("map_rd_data", f2hData_out, 8'h33);
        check("map_rd_valid", f2hValid_out, 1'b1);
        check("map_rd_ack", epF2hReady_out, 4'b0100);
        f2hReady_in = 1'b0;
        #1 check("map_rd_noack", epF2hReady_out, 4'b0000);
        epF2hValid_in = 4'b0000;
        #1 check("map_rd_invalid", f2hValid_out, 1'b0);
        tick();

`ifdef CHAN_ROUTER_STATUS_EN
        // Status channel: clear, build 0x0102 / 0x0003, read five bytes, clear again.
        chanAddr_in = 7'd127; h2fData_in = 8'h00; h2fValid_in = 1'b1;
        tick();
        h2fValid_in = 1'b0;
        #1 check("st_clr_bytes", byteCount_out, 16'd0); check("st_clr_drops", dropCount_out, 16'd0);
        chanAddr_in = 7'd0; h2fValid_in = 1'b1;
        tick(258);
        chanAddr_in = 7'd40;
        tick(3);
        h2fValid_in = 1'b0;
        tick();
        check("st_bytes", byteCount_out, 16'h0102); check("st_drops", dropCount_out, 16'h0003);
        stat_exp = '{8'h02, 8'h01, 8'h03, 8'h00, 8'h02};
        chanAddr_in = 7'd127; f2hReady_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1 check("st_rd_data", f2hData_out, stat_exp[k]);
            check("st_rd_valid", f2hValid_out, 1'b1);
            check("st_rd_ack", epF2hReady_out, 4'b0000);
            tick();
        end
        f2hReady_in = 1'b0; h2fData_in = 8'hAA; h2fValid_in = 1'b1;
        tick();
        h2fValid_in = 1'b0;
        #1 check("st_wr_bytes", byteCount_out, 16'd0); check("st_wr_drops", dropCount_out, 16'd0);
`else
        // Without the status feature, address 127 behaves as any unmapped address.
        stat_exp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        chanAddr_in = 7'd127; h2fData_in = 8'hAA; h2fValid_in = 1'b1;
        tick();
        h2fValid_in = 1'b0; f2hReady_in = 1'b1;
        #1 check("s127_drops", dropCount_out, 16'd3);
        check("s127_rd_data", f2hData_out, stat_exp[0]);
        check("s127_rd_valid", f2hValid_out, 1'b1);
        f2hReady_in = 1'b0;
`endif
        tick();

        // Asynchronous reset with a byte pending.
        base = got.size();
        epH2fReady_in = 4'b1101; chanAddr_in = 7'd1; h2fData_in = 8'h99; h2fValid_in = 1'b1;
        tick();
        h2fValid_in = 1'b0;
        #1 check("ar_pending", epH2fValid_out, 4'b0010);
        #1 reset_in = 1'b1;
        #1 check("ar_valid", epH2fValid_out, 4'b0000);
        check("ar_ready", h2fReady_out, 1'b1);
        check("ar_bytes", byteCount_out, 16'd0);
        check("ar_drops", dropCount_out, 16'd0);
        tick(2);
        reset_in = 1'b0; epH2fReady_in = 4'b1111;
        tick(3);
        check("ar_no_delivery", 32'(got.size()), 32'(base));
        check("ar_idle", epH2fValid_out, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
